program_loader: RTL

- Upstream feeder for the processor's load interface. Takes a stream of 32-bit words over a valid/ready handshake and drives the processor's load port.
- Sequences the load: instruction section first, then data section. Then asserts start_signal and waits for end_signal.
- Replaces hand-timed bench stimulus with a deterministic, checkable sequencer.

---
 rtl/program_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: streams instruction then data words into the processor load
// port, then starts the processor and waits for it to report completion.
module program_loader #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    input  logic             in_last,
    output logic [31:0]      new_instruction,
    output logic             load_we,
    output logic             add_into,
    output logic             start_signal,
    input  logic             end_signal,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] data_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned WORD_W = 32;
    localparam logic [CNT_W-1:0] I_MAX = CNT_W'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0] D_MAX = CNT_W'(DMEM_DEPTH);

    typedef enum logic [2:0] {
        S_LOAD_I,
        S_LOAD_D,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               we_q, we_d;
    logic               add_q, add_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic [CNT_W-1:0]   dcnt_q, dcnt_d;
    logic               xfer;

    // Accept words only while a section is being loaded; never looks at in_valid.
    always_comb begin
        in_ready = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
    end

    // Next-state, counters and registered load-port outputs.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        we_d    = 1'b0;
        add_d   = add_q;
        icnt_d  = icnt_q;
        dcnt_d  = dcnt_q;
        xfer    = in_valid && in_ready;

        if (xfer) begin
            word_d = in_word;
            we_d   = 1'b1;
        end

        case (state_q)
            S_LOAD_I: begin
                if (xfer) begin
                    icnt_d = icnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = S_LOAD_D;
                    end else if (icnt_d == I_MAX) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_LOAD_D: begin
                // Target flips so the first data word is presented with add_into=1
                // while the last instruction word still goes out with add_into=0.
                add_d = 1'b1;
                if (xfer) begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = S_ARM;
                    end else if (dcnt_d == D_MAX) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (end_signal) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        start_d = (state_d == S_RUN);
        busy_d  = (state_d != S_DONE) && (state_d != S_ERR);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD_I;
            word_q  <= '0;
            we_q    <= 1'b0;
            add_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            icnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            we_q    <= we_d;
            add_q   <= add_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign new_instruction = word_q;
    assign load_we         = we_q;
    assign add_into        = add_q;
    assign start_signal    = start_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign instr_count     = icnt_q;
    assign data_count      = dcnt_q;

endmodule
